// File: rtl/txn_seq_gen.sv
// txn_seq_gen: accepts one buffered request on a valid/ready port and plays it
// out as the fixed four-cycle bus pattern START / DATA / BE / END.
// Bus outputs are registered from the next state so each one lines up exactly
// with the cycle its state occupies. A completed-transaction counter is kept.
module txn_seq_gen #(
  parameter int DATA_W = 8,
  parameter int BE_W   = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_data,
  input  logic [BE_W-1:0]   req_be,
  output logic              start_sig,
  output logic              frame,
  output logic [DATA_W-1:0] data_bus,
  output logic [BE_W-1:0]   c_be,
  output logic              end_sig,
  output logic              busy,
  output logic [CNT_W-1:0]  txn_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_BE    = 3'd3,
    S_END   = 3'd4
  } state_t;

  state_t state_reg, state_next;

  // One-deep request buffer and the working copy of the transaction in flight
  logic              hold_valid_reg;
  logic [DATA_W-1:0] hold_data_reg;
  logic [BE_W-1:0]   hold_be_reg;
  logic [DATA_W-1:0] work_data_reg;
  logic [BE_W-1:0]   work_be_reg;

  // Registered bus outputs and their next-state decodes
  logic              start_reg, start_next;
  logic              frame_reg, frame_next;
  logic [DATA_W-1:0] data_reg, data_next;
  logic [BE_W-1:0]   be_reg, be_next;
  logic              end_reg, end_next;
  logic [CNT_W-1:0]  count_reg;

  logic load;
  logic drain;

  assign req_ready = !hold_valid_reg;
  assign load      = req_valid && !hold_valid_reg;
  // START is only entered from IDLE or END, and always consumes the buffer
  assign drain     = (state_next == S_START);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: fixed walk through the pattern, restart from END if buffered
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  state_next = hold_valid_reg ? S_START : S_IDLE;
      S_START: state_next = S_DATA;
      S_DATA:  state_next = S_BE;
      S_BE:    state_next = S_END;
      S_END:   state_next = hold_valid_reg ? S_START : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output decode from the next state, so the registered copy matches the state
  always_comb begin
    start_next = 1'b0;
    frame_next = 1'b1;
    data_next  = '0;
    be_next    = '0;
    end_next   = 1'b0;
    case (state_next)
      S_START: start_next = 1'b1;
      S_DATA: begin
        frame_next = 1'b0;
        data_next  = work_data_reg;
      end
      S_BE:    be_next    = work_be_reg;
      S_END:   end_next   = 1'b1;
      default: ;
    endcase
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      start_reg <= 1'b0;
      frame_reg <= 1'b1;
      data_reg  <= '0;
      be_reg    <= '0;
      end_reg   <= 1'b0;
    end else begin
      start_reg <= start_next;
      frame_reg <= frame_next;
      data_reg  <= data_next;
      be_reg    <= be_next;
      end_reg   <= end_next;
    end
  end

  // Hold buffer: filled on a handshake, emptied when its request starts
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid_reg <= 1'b0;
      hold_data_reg  <= '0;
      hold_be_reg    <= '0;
    end else if (load) begin
      hold_valid_reg <= 1'b1;
      hold_data_reg  <= req_data;
      hold_be_reg    <= req_be;
    end else if (drain) begin
      hold_valid_reg <= 1'b0;
    end
  end

  // Working registers capture the buffered request as its START begins
  always_ff @(posedge clk) begin
    if (rst) begin
      work_data_reg <= '0;
      work_be_reg   <= '0;
    end else if (drain) begin
      work_data_reg <= hold_data_reg;
      work_be_reg   <= hold_be_reg;
    end
  end

  // Completed-transaction counter, bumped on the edge leaving END; wraps freely
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (state_reg == S_END) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign start_sig = start_reg;
  assign frame     = frame_reg;
  assign data_bus  = data_reg;
  assign c_be      = be_reg;
  assign end_sig   = end_reg;
  assign busy      = (state_reg != S_IDLE);
  assign txn_count = count_reg;

endmodule

// File: tb/tb_txn_seq_gen.sv
// Bench for txn_seq_gen: directed requests are queued as expected transactions
// when accepted; an independent monitor walks the bus pattern and scores it.
module tb_txn_seq_gen;

  localparam int DW = 8;
  localparam int BW = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [DW-1:0] req_data = '0;
  logic [BW-1:0] req_be = '0;
  logic          start_sig;
  logic          frame;
  logic [DW-1:0] data_bus;
  logic [BW-1:0] c_be;
  logic          end_sig;
  logic          busy;
  logic [CW-1:0] txn_count;

  txn_seq_gen #(.DATA_W(DW), .BE_W(BW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_be(req_be), .start_sig(start_sig),
    .frame(frame), .data_bus(data_bus), .c_be(c_be), .end_sig(end_sig),
    .busy(busy), .txn_count(txn_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [BW-1:0] be;
  } txn_t;

  txn_t          exp_q[$];
  int            tests = 0;
  int            fails = 0;
  int            phase = 0;
  txn_t          cur;
  logic [CW-1:0] exp_count = '0;
  int            gapless = 0;
  logic          prev_end = 1'b0;
  int            w;
  int            g0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Monitor: follows the four-cycle pattern and compares against the queue
  always @(negedge clk) begin
    if (rst) begin
      phase = 0;
      exp_count = '0;
      prev_end = 1'b0;
    end else begin
      check("txn_count", 32'(txn_count), 32'(exp_count));
      case (phase)
        0: begin
          if (start_sig) begin
            if (prev_end) gapless++;
            check("queue_nonempty_at_start", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) cur = exp_q.pop_front();
            else cur = '0;
            check("start_frame", 32'(frame), 1);
            check("start_data_bus", 32'(data_bus), 0);
            check("start_c_be", 32'(c_be), 0);
            check("start_end_sig", 32'(end_sig), 0);
            check("start_busy", 32'(busy), 1);
            $display("[TB] START  data=%02h be=%01h count=%0d", cur.d, cur.be, txn_count);
            phase = 1;
          end else begin
            check("idle_pattern", {28'd0, frame, end_sig, busy, 1'b0} | 32'(data_bus) << 8 | 32'(c_be) << 16, 32'h8);
          end
          prev_end = 1'b0;
        end
        1: begin
          check("data_frame", 32'(frame), 0);
          check("data_bus", 32'(data_bus), 32'(cur.d));
          check("data_other", {29'd0, start_sig, end_sig, busy} | 32'(c_be) << 8, 32'h1);
          phase = 2;
        end
        2: begin
          check("be_c_be", 32'(c_be), 32'(cur.be));
          check("be_other", {28'd0, start_sig, end_sig, frame, busy} | 32'(data_bus) << 8, 32'h3);
          phase = 3;
        end
        default: begin
          check("end_end_sig", 32'(end_sig), 1);
          check("end_other", {29'd0, start_sig, frame, busy} | 32'(data_bus) << 8 | 32'(c_be) << 16, 32'h3);
          $display("[TB] END    data=%02h be=%01h", cur.d, cur.be);
          exp_count = exp_count + 1'b1;
          prev_end = 1'b1;
          phase = 0;
        end
      endcase
    end
  end

  // Protocol property mirroring start_sig ##1 s2(a,b) ##1 end_sig
  property p_seq;
    @(posedge clk) disable iff (rst)
      start_sig |=> (!frame && !start_sig) ##1 (frame && !end_sig) ##1 end_sig;
  endproperty
  a_seq: assert property (p_seq) else begin
    fails++;
    $display("FAIL sva_seq at t=%0t", $time);
  end

  // Offer one request and hold it until accepted; queue it as expected output
  task automatic send(input logic [DW-1:0] d, input logic [BW-1:0] be, output int waited);
    logic acc;
    req_valid = 1'b1;
    req_data  = d;
    req_be    = be;
    waited    = 0;
    acc       = 1'b0;
    while (!acc && waited < 50) begin
      acc = req_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    if (!acc) begin
      check("accept_timeout", 0, 1);
    end else begin
      exp_q.push_back('{d: d, be: be});
      $display("[TB] ACCEPT data=%02h be=%01h after %0d edge(s)", d, be, waited);
    end
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      #2;
      if (exp_q.size() == 0 && phase == 0 && !busy) done = 1'b1;
    end
    check("wait_idle_timeout", 32'(done), 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and idle
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_outputs", {25'd0, start_sig, frame, end_sig, busy, req_ready, 2'b0}
                         | 32'(data_bus) << 8 | 32'(c_be) << 16 | 32'(txn_count) << 20, 32'h24);
    repeat (10) @(posedge clk);
    #1;

    // Single transaction with start latency check
    send(8'hA5, 4'b1010, w);
    req_valid = 1'b0;
    check("single_wait", w, 1);
    check("single_start_not_yet", 32'(start_sig), 0);
    check("single_busy_not_yet", 32'(busy), 0);
    @(posedge clk);
    #1;
    check("single_start_e1", 32'(start_sig), 1);
    check("single_busy_e1", 32'(busy), 1);
    check("single_ready_e1", 32'(req_ready), 1);
    wait_idle();
    check("single_count", 32'(txn_count), 1);

    // Back-to-back with req_valid held
    g0 = gapless;
    send(8'h11, 4'h1, w);
    send(8'h22, 4'h2, w);
    req_valid = 1'b0;
    check("b2b_second_wait", w, 2);
    wait_idle();
    check("b2b_gapless", gapless, g0 + 1);
    check("b2b_count", 32'(txn_count), 3);

    // Back-pressure: three continuous requests
    g0 = gapless;
    send(8'h31, 4'h3, w);
    send(8'h32, 4'h4, w);
    check("bp_second_wait", w, 2);
    check("bp_ready_low_hold_full", 32'(req_ready), 0);
    send(8'h33, 4'h5, w);
    req_valid = 1'b0;
    check("bp_third_wait", w, 4);
    wait_idle();
    check("bp_gapless", gapless, g0 + 2);
    check("bp_count", 32'(txn_count), 6);

    // Reset during DATA with a second request buffered
    send(8'h41, 4'h6, w);
    send(8'h42, 4'h7, w);
    req_valid = 1'b0;
    check("rmid_in_data", 32'(frame), 0);
    check("rmid_hold_full", 32'(req_ready), 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    check("rmid_after", {27'd0, start_sig, frame, end_sig, busy, req_ready}
                        | 32'(data_bus) << 8 | 32'(txn_count) << 16, 32'h9);
    repeat (8) @(posedge clk);
    #1;
    check("rmid_still_idle", 32'(busy), 0);

    // Counter wrap with CNT_W=4: 17 transactions back-to-back
    for (int i = 0; i < 17; i++) begin
      send(8'(8'h50 + i), 4'(i), w);
    end
    req_valid = 1'b0;
    wait_idle();
    check("wrap_count", 32'(txn_count), 1);

    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
